yaya_istek_birimi: RTL



---
 rtl/yaya_istek_birimi.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/yaya_istek_birimi.sv
// yaya_istek_birimi -- pedestrian request front end.
// Synchronizes and debounces the active-low push-button. Latches one request
// until the sequencer acknowledges it, then ignores presses for a number of
// ticks. Also generates the shared timebase strobe 'tick'.
// Build option: define YAYA_ISTEK_SAYAC_EN to build the saturating count of
// accepted requests (req_count). Without it req_count is tied to zero.
module yaya_istek_birimi #(
  parameter int CLK_HZ        = 27_000_000,
  parameter int DEBOUNCE_MS   = 20,
  parameter int TICK_MS       = 500,
  parameter int LOCKOUT_TICKS = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       btn_n,
  input  logic       ped_ack,
  output logic       tick,
  output logic       ped_req,
  output logic       btn_level,
  output logic [7:0] req_count
);

  // Derived cycle counts, clamped so tiny clock rates still give a working block.
  localparam int DB_RAW      = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int DB_CYCLES   = (DB_RAW < 1) ? 1 : DB_RAW;
  localparam int TICK_RAW    = CLK_HZ / 1000 * TICK_MS;
  localparam int TICK_CYCLES = (TICK_RAW < 2) ? 2 : TICK_RAW;

  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int TK_W = $clog2(TICK_CYCLES);
  localparam int LK_W = (LOCKOUT_TICKS < 2) ? 1 : $clog2(LOCKOUT_TICKS + 1);

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [TK_W-1:0] TICK_LAST = TK_W'(TICK_CYCLES - 1);
  localparam logic [LK_W-1:0] LOCK_INIT = LK_W'(LOCKOUT_TICKS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_LOCKOUT = 2'd2
  } req_state_t;

  // Synchronizer, debounce and timebase state.
  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [TK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic            press_evt;

  // Request FSM state.
  req_state_t      state_q;
  logic            ped_req_q;
  logic [LK_W-1:0] lock_cnt_q;

  // Two-flop synchronizer; idles at 1 (button released).
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
    end
  end

  // Debounce next state: the stable value follows the synchronized value only
  // after it has differed for DB_CYCLES consecutive cycles.
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = '0;
    if (sync2_q != stable_q) begin
      if (db_cnt_q == DB_LAST) begin
        stable_d = sync2_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  // A press is the stable value falling 1->0; it is acted on by the FSM on
  // the same edge that updates the stable value, so btn_level and ped_req
  // rise together.
  assign press_evt = stable_q & ~stable_d;

  // Debounce registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stable_q <= 1'b1;
      db_cnt_q <= '0;
    end else begin
      stable_q <= stable_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Free-running timebase next state, wrapping at TICK_CYCLES-1.
  always_comb begin
    tick_cnt_d = tick_cnt_q + TK_W'(1);
    if (tick_cnt_q == TICK_LAST) begin
      tick_cnt_d = '0;
    end
  end

  // Timebase counter register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign tick = (tick_cnt_q == TICK_LAST);

  // Request FSM: IDLE takes a press, PENDING waits for the acknowledge,
  // LOCKOUT counts ticks before presses are accepted again. The tick that
  // coincides with the acknowledge is not counted because PENDING ignores it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= S_IDLE;
      ped_req_q  <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (press_evt) begin
            state_q   <= S_PENDING;
            ped_req_q <= 1'b1;
          end
        end
        S_PENDING: begin
          if (ped_ack) begin
            ped_req_q  <= 1'b0;
            lock_cnt_q <= LOCK_INIT;
            state_q    <= (LOCKOUT_TICKS == 0) ? S_IDLE : S_LOCKOUT;
          end
        end
        S_LOCKOUT: begin
          if (tick) begin
            if (lock_cnt_q == LK_W'(1)) begin
              state_q    <= S_IDLE;
              lock_cnt_q <= '0;
            end else begin
              lock_cnt_q <= lock_cnt_q - LK_W'(1);
            end
          end
        end
        default: begin
          state_q   <= S_IDLE;
          ped_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign ped_req   = ped_req_q;
  assign btn_level = ~stable_q;

`ifdef YAYA_ISTEK_SAYAC_EN
  logic [7:0] req_count_q;
  logic       accept;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A request is accepted exactly when IDLE sees a press.
  assign accept = (state_q == S_IDLE) && press_evt;

  // Saturating count of accepted requests.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      req_count_q <= 8'd0;
    end else if (accept) begin
      req_count_q <= sat_inc8(req_count_q);
    end
  end

  assign req_count = req_count_q;
`else
  assign req_count = 8'd0;
`endif

endmodule
